unsint_to_float: RTL and testbench

//  Multi-cycle converter from a 32-bit unsigned integer to an IEEE-754 single-precision float.
//  It is the integer-side neighbour of the float-to-unsigned converter in the FPU.
//  It uses the same free-running get/convert/put FSM with an en/complete handshake.

---
 rtl/fpu_pkg.sv | 16 +
 rtl/unsint_to_float.sv | 86 ++++++++
 tb/tb_unsint_to_float.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU constants and converter FSM state encodings.
package fpu_pkg;
  localparam int INT_W = 32;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;

  typedef enum logic [2:0] {
    GET_A   = 3'd0,
    SPECIAL = 3'd1,
    NORM    = 3'd2,
    ROUND   = 3'd3,
    PACK    = 3'd4,
    PUT_Z   = 3'd5
  } state_t;
endpackage

// File: rtl/unsint_to_float.sv
// Iterative 32-bit unsigned integer to IEEE-754 single converter,
// round-to-nearest-even, free-running get/convert/put FSM.
module unsint_to_float
  import fpu_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [INT_W-1:0]         input_a,
  output logic [INT_W-1:0]         output_z,
  output logic                     complete
);

  state_t                  state;
  logic [INT_W-1:0]        a;
  logic [INT_W-1:0]        m;
  logic signed [EXP_W:0]   e;
  logic [MAN_W-1:0]        mant;
  logic [INT_W-1:0]        z;

  // m[31] is always set in ROUND, so a carry out of the 24-bit mantissa
  // happens exactly when the stored 23 bits are all ones; the wrapped
  // increment is then already the 0x800000 fraction.
  logic             round_up;
  logic             carry;
  logic [MAN_W-1:0] mant_inc;
  logic [EXP_W-1:0] exp_field;

  assign round_up  = m[7] & (m[6] | (|m[5:0]) | m[8]);
  assign mant_inc  = m[30:8] + MAN_W'(1);
  assign carry     = round_up & (&m[30:8]);
  assign exp_field = EXP_W'(e) + EXP_W'(BIAS);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= GET_A;
      output_z <= '0;
      complete <= 1'b0;
    end else if (!en) begin
      output_z <= '0;
      complete <= 1'b0;
    end else begin
      case (state)
        GET_A: begin
          a        <= input_a;
          complete <= 1'b0;
          state    <= SPECIAL;
        end
        SPECIAL: begin
          if (a == '0) begin
            z     <= '0;
            state <= PUT_Z;
          end else begin
            m     <= a;
            e     <= 9'sd31;
            state <= NORM;
          end
        end
        NORM: begin
          if (!m[31]) begin
            m <= m << 1;
            e <= e - 9'sd1;
          end else begin
            state <= ROUND;
          end
        end
        ROUND: begin
          mant <= round_up ? mant_inc : m[30:8];
          if (carry) e <= e + 9'sd1;
          state <= PACK;
        end
        PACK: begin
          z     <= {1'b0, exp_field, mant};
          state <= PUT_Z;
        end
        PUT_Z: begin
          output_z <= z;
          complete <= 1'b1;
          state    <= GET_A;
        end
        default: state <= GET_A;
      endcase
    end
  end

endmodule

// File: tb/tb_unsint_to_float.sv
// Directed-vector bench with scoreboard queue and independent monitor.
module tb_unsint_to_float;
  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] input_a;
  logic [31:0] output_z;
  logic        complete;

  unsint_to_float dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .input_a  (input_a),
    .output_z (output_z),
    .complete (complete)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] z;
    int          lat;
    int          issue;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every complete pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (complete) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_complete: output_z=%h with no pending conversion", output_z);
      end else begin
        exp_t x;
        int   lat;
        x   = sb.pop_front();
        lat = cyc - x.issue + 1;
        checks++;
        if (output_z !== x.z) begin
          errors++;
          $display("FAIL result a=%h: got %h expected %h", x.a, output_z, x.z);
        end
        checks++;
        if (lat != x.lat) begin
          errors++;
          $display("FAIL latency a=%h: got %0d expected %0d", x.a, lat, x.lat);
        end
      end
    end
  end

  task automatic check_idle(input string name);
    checks++;
    if (output_z !== 32'h0 || complete !== 1'b0) begin
      errors++;
      $display("FAIL %s: output_z=%h complete=%b expected 00000000/0", name, output_z, complete);
    end
  endtask

  // Called on a negedge; the following posedge is the GET_A sample.
  task automatic start(input logic [31:0] a, input logic [31:0] z, input int lat);
    exp_t x;
    input_a = a;
    x.a = a; x.z = z; x.lat = lat; x.issue = cyc + 1;
    sb.push_back(x);
  endtask

  task automatic wait_complete(input logic [31:0] a);
    bit seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (complete) begin seen = 1; break; end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL timeout a=%h: complete=0 expected 1 within 100 cycles", a);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] z, input int lat);
    start(a, z, lat);
    wait_complete(a);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; input_a = '0;
    repeat (2) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;

    issue(32'h00000000, 32'h00000000, 3);
    issue(32'h00000001, 32'h3F800000, 37);
    issue(32'h80000000, 32'h4F000000, 6);
    issue(32'hFFFFFFFF, 32'h4F800000, 6);
    issue(32'h01000001, 32'h4B800000, 13);
    issue(32'h01000003, 32'h4B800002, 13);
    issue(32'h00000003, 32'h40400000, 36);
    issue(32'h12345678, 32'h4D91A2B4, 9);
    issue(32'h00FFFFFF, 32'h4B7FFFFF, 14);

    // en low for 5 cycles while normalising a=1; result unchanged, 5 cycles later.
    start(32'h00000001, 32'h3F800000, 42);
    repeat (6) @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_idle("en_low");
    end
    en = 1'b1;
    wait_complete(32'h00000001);

    // Reset while the FSM sits in ROUND; no result may appear from it.
    input_a = 32'h80000000;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_idle("rst_mid_round");
    rst = 1'b0;
    issue(32'h80000000, 32'h4F000000, 6);
    issue(32'h01000003, 32'h4B800002, 13);

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d pending expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
